// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM state type and index/width helpers
// for the keypad scanner slice.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_REPORT   = 2'd2,
        ST_RELEASE  = 2'd3
    } kp_state_t;

    function automatic int lsb_index(input logic [31:0] v);
        int idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

    function automatic int code_width(input int rows, input int cols);
        return (rows * cols > 1) ? $clog2(rows * cols) : 1;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// keypad_sync: two-flop synchroniser for the raw column lines,
// asynchronous active-low reset to 0.
module keypad_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: row-scanning matrix keypad with debounce and valid/ready events.
// Define KEYPAD_REPEAT_EN to build the auto-repeat hold counter.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int SCAN_CYCLES     = 4,
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int REPEAT_CYCLES   = 5000,
    localparam int KW             = code_width(ROWS, COLS)
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic [ROWS-1:0] row,
    input  logic [COLS-1:0] col,
    output logic            key_valid,
    input  logic            key_ready,
    output logic [KW-1:0]   key_code,
    output logic            key_multi,
    output logic            key_repeat,
    output logic            key_down
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int DW = $clog2(SCAN_CYCLES + 1);
    localparam int BW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [ROWS-1:0] ROW0 = ROWS'(1);

    if (ROWS < 2 || COLS < 2 || SCAN_CYCLES < 1 ||
        DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_cfg
        $error("keypad_scanner: illegal parameter set");
    end

    kp_state_t       state, state_n;
    logic [COLS-1:0] cols;
    logic [ROWS-1:0] row_n, row_nx;
    logic [DW-1:0]   dwell, dwell_n;
    logic [BW-1:0]   cnt, cnt_n;
    logic [CW-1:0]   cidx, cidx_n;
    logic [KW-1:0]   code_n;
    logic            multi_n;
    logic            hit;
`ifdef KEYPAD_REPEAT_EN
    localparam int HW = $clog2(REPEAT_CYCLES + 1);
    logic [HW-1:0]   hold, hold_n;
    logic            rep_n;
`endif

    keypad_sync #(.W(COLS)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (col),
        .q       (cols)
    );

    assign row_nx    = {row[ROWS-2:0], row[ROWS-1]};
    assign key_valid = (state == ST_REPORT);
    assign key_down  = (state == ST_REPORT) || (state == ST_RELEASE);

    always_comb begin
        state_n = state;
        row_n   = row;
        dwell_n = dwell;
        cnt_n   = cnt;
        cidx_n  = cidx;
        code_n  = key_code;
        multi_n = key_multi;
        hit     = cols[cidx];
`ifdef KEYPAD_REPEAT_EN
        hold_n  = hold;
        rep_n   = key_repeat;
`endif
        case (state)
            ST_SCAN: begin
                if (dwell == DW'(SCAN_CYCLES - 1)) begin
                    dwell_n = '0;
                    if (cols == '0) begin
                        row_n = row_nx;
                    end else begin
                        state_n = ST_DEBOUNCE;
                        cnt_n   = '0;
                        cidx_n  = CW'(lsb_index(32'(cols)));
                        code_n  = KW'(lsb_index(32'(row)) * COLS +
                                      lsb_index(32'(cols)));
                        multi_n = ($countones(cols) > 1);
`ifdef KEYPAD_REPEAT_EN
                        rep_n   = 1'b0;
`endif
                    end
                end else begin
                    dwell_n = dwell + 1'b1;
                end
            end
            ST_DEBOUNCE: begin
                if (!hit) begin
                    state_n = ST_SCAN;
                    row_n   = row_nx;
                    dwell_n = '0;
                    cnt_n   = '0;
                end else if (cnt == BW'(DEBOUNCE_CYCLES - 1)) begin
                    state_n = ST_REPORT;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_REPORT: begin
                // the event stays up even if the key lets go here
                if (key_ready) begin
                    state_n = ST_RELEASE;
                    cnt_n   = '0;
`ifdef KEYPAD_REPEAT_EN
                    hold_n  = '0;
`endif
                end
            end
            ST_RELEASE: begin
                if (hit) begin
                    cnt_n = '0;
`ifdef KEYPAD_REPEAT_EN
                    if (hold == HW'(REPEAT_CYCLES - 1)) begin
                        state_n = ST_REPORT;
                        hold_n  = '0;
                        rep_n   = 1'b1;
                    end else begin
                        hold_n = hold + 1'b1;
                    end
`endif
                end else begin
`ifdef KEYPAD_REPEAT_EN
                    hold_n = '0;
`endif
                    if (cnt == BW'(DEBOUNCE_CYCLES - 1)) begin
                        state_n = ST_SCAN;
                        row_n   = row_nx;
                        dwell_n = '0;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_n = ST_SCAN;
                row_n   = ROW0;
                dwell_n = '0;
                cnt_n   = '0;
            end
        endcase
        // a corrupted row drive restarts the scan from row 0
        if (!$onehot(row)) begin
            state_n = ST_SCAN;
            row_n   = ROW0;
            dwell_n = '0;
            cnt_n   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_SCAN;
            row       <= ROW0;
            dwell     <= '0;
            cnt       <= '0;
            cidx      <= '0;
            key_code  <= '0;
            key_multi <= 1'b0;
        end else begin
            state     <= state_n;
            row       <= row_n;
            dwell     <= dwell_n;
            cnt       <= cnt_n;
            cidx      <= cidx_n;
            key_code  <= code_n;
            key_multi <= multi_n;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold       <= '0;
            key_repeat <= 1'b0;
        end else begin
            hold       <= hold_n;
            key_repeat <= rep_n;
        end
    end
`else
    assign key_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed checks of scanning, debounce, handshake
// and reset behaviour against a simple keypad matrix model.
module tb_keypad_scanner;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP = 32;
`else
    localparam int REP = 5000;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        key_valid;
    logic        key_ready;
    logic [3:0]  key_code;
    logic        key_multi;
    logic        key_repeat;
    logic        key_down;
    logic [15:0] keys;
    logic [3:0]  glitch;
    int          tests = 0;
    int          fails = 0;
    int          events = 0;

    keypad_scanner #(
        .ROWS            (4),
        .COLS            (4),
        .SCAN_CYCLES     (4),
        .DEBOUNCE_CYCLES (8),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .row        (row),
        .col        (col),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_code   (key_code),
        .key_multi  (key_multi),
        .key_repeat (key_repeat),
        .key_down   (key_down)
    );

    always #5 clk = ~clk;

    // keypad matrix: a pressed key connects its row drive to its column
    always_comb begin
        col = glitch;
        for (int r = 0; r < 4; r++) begin
            if (row[r]) col = col | keys[r*4 +: 4];
        end
    end

    always @(posedge clk) begin
        if (reset_n && key_valid && key_ready) events <= events + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int budget, input string tag);
        int n = 0;
        while (key_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(tag, key_valid, 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (key_down !== 1'b0 && n < 80) begin
            tick();
            n++;
        end
        check(tag, key_down, 0);
    endtask

    initial begin
        int base;
        int n;
        logic [3:0] r0;
        reset_n   = 1'b0;
        key_ready = 1'b1;
        keys      = '0;
        glitch    = '0;

        // reset state
        repeat (3) tick();
        check("rst_row", row, 4'b0001);
        check("rst_valid", key_valid, 0);
        check("rst_code", key_code, 0);
        check("rst_multi", key_multi, 0);
        check("rst_repeat", key_repeat, 0);
        check("rst_down", key_down, 0);

        // row stepping every 4 cycles
        reset_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 3) check("scan_hold", row, 4'b0001);
            if (i % 4 == 0)
                check("scan_step", row, 4'b0001 << ((i / 4) % 4));
        end

        // clean press at row 2, col 1
        base = events;
        keys = 16'h0001 << 9;
        wait_valid(100, "press_valid");
        check("press_code", key_code, 9);
        check("press_multi", key_multi, 0);
        check("press_repeat", key_repeat, 0);
        check("press_down", key_down, 1);
        repeat (15) tick();
        check("press_once", events, base + 1);
        check("press_vdrop", key_valid, 0);
        check("press_held", key_down, 1);
        keys = '0;
        repeat (9) tick();
        check("down_hold", key_down, 1);
        tick();
        check("down_drop", key_down, 0);

        // short bounce on col[3]
        base = events;
        repeat (3) tick();
        glitch = 4'b1000;
        repeat (3) tick();
        glitch = 4'b0000;
        repeat (40) tick();
        check("bounce_none", events, base);
        check("bounce_down", key_down, 0);
        r0 = row;
        n  = 0;
        while (row === r0 && n < 8) begin
            tick();
            n++;
        end
        check("bounce_rescan", (row !== r0), 1);

        // release glitches while in RELEASE
        base = events;
        keys = 16'h0001 << 6;
        wait_valid(100, "rglitch_valid");
        check("rglitch_code", key_code, 6);
        repeat (5) tick();
        keys = '0;
        repeat (5) tick();
        keys = 16'h0001 << 6;
        repeat (2) tick();
        keys = '0;
        repeat (4) tick();
        keys = 16'h0001 << 6;
        tick();
        keys = '0;
        repeat (30) tick();
        check("rglitch_once", events, base + 1);
        check("rglitch_down", key_down, 0);

        // backpressure, key released while the event is pending
        key_ready = 1'b0;
        base = events;
        keys = 16'h0001 << 12;
        wait_valid(100, "bp_valid");
        check("bp_code0", key_code, 12);
        for (int i = 0; i < 50; i++) begin
            tick();
            if (i == 10) keys = '0;
            check("bp_hold_valid", key_valid, 1);
            check("bp_hold_code", key_code, 12);
        end
        key_ready = 1'b1;
        tick();
        check("bp_accept", key_valid, 0);
        check("bp_once", events, base + 1);
        wait_idle("bp_idle");

        // two columns on row 0
        keys = 16'h0006;
        wait_valid(100, "multi_valid");
        check("multi_code", key_code, 1);
        check("multi_flag", key_multi, 1);
        keys = '0;
        wait_idle("multi_idle");

        // reset while an event is pending
        key_ready = 1'b0;
        base = events;
        keys = 16'h0001 << 5;
        wait_valid(100, "rmid_valid");
        check("rmid_code", key_code, 5);
        #2;
        reset_n = 1'b0;
        #1;
        check("rmid_vclr", key_valid, 0);
        check("rmid_cclr", key_code, 0);
        check("rmid_dclr", key_down, 0);
        check("rmid_row", row, 4'b0001);
        keys = '0;
        tick();
        reset_n   = 1'b1;
        key_ready = 1'b1;
        repeat (3) tick();
        check("rmid_discard", events, base);

`ifdef KEYPAD_REPEAT_EN
        // held key auto-repeats
        keys = 16'h0001 << 10;
        wait_valid(100, "rep_first");
        check("rep_first_flag", key_repeat, 0);
        check("rep_first_code", key_code, 10);
        tick();
        n = 1;
        while (key_valid !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        check("rep_valid", key_valid, 1);
        check("rep_flag", key_repeat, 1);
        check("rep_code", key_code, 10);
        check("rep_period", (n >= 30 && n <= 36), 1);
        keys = '0;
        wait_idle("rep_idle");
        keys = 16'h0001 << 3;
        wait_valid(100, "rep_new_valid");
        check("rep_new_flag", key_repeat, 0);
        check("rep_new_code", key_code, 3);
        keys = '0;
        wait_idle("rep_new_idle");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
